uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Desc   : Lends one UART transmitter to one of NREQ byte FIFOs per message.
//          Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Rev    : 1.0  initial release
// ============================================================================

module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_empty,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_rden,
  output logic [W-1:0]      uart_data,
  output logic              uart_start,
  input  logic              uart_busy,
  output logic [NREQ-1:0]   grant,
  output logic              msg_done
);

  localparam int              c_PTR_W = $clog2(NREQ);
  localparam logic [NREQ-1:0] c_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [c_PTR_W-1:0] r_gidx, w_gidx_nxt;
  logic [c_PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [c_PTR_W-1:0] w_win_idx;
  logic               w_win_found;
  logic [W-1:0]       r_data, w_data_nxt, w_sel_data;
  logic               r_start, w_start_nxt;
  logic               r_done, w_done_nxt;
  logic               w_g_avail;

  // Winner search over the non-empty sources.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!w_win_found && !req_empty[i]) begin
        w_win_found = 1'b1;
        w_win_idx   = c_PTR_W'(i);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_win_found && !req_empty[i] && (i == ((int'(r_ptr) + k) % NREQ))) begin
          w_win_found = 1'b1;
          w_win_idx   = c_PTR_W'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_sel_data = req_data[i*W +: W];
      end
    end
  end

  assign w_g_avail = |(r_grant & ~req_empty);

  // Read strobe is a pure decode of state and grant, never of uart_busy.
  assign req_rden = (r_state == S_READ) ? r_grant : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_data_nxt  = r_data;
    w_start_nxt = r_start;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_grant_nxt = c_ONE << w_win_idx;
          w_gidx_nxt  = w_win_idx;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        // FIFO Q is valid one cycle after RdEn; a zero byte ends the message.
        if (w_sel_data == '0) begin
          w_done_nxt  = 1'b1;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_gidx == c_PTR_W'(NREQ-1)) ? '0 : r_gidx + 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_data_nxt  = w_sel_data;
          w_start_nxt = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (uart_busy) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!uart_busy) begin
          w_state_nxt = w_g_avail ? S_READ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_g_avail) begin
          w_state_nxt = S_READ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_data  <= w_data_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign grant      = r_grant;
  assign uart_data  = r_data;
  assign uart_start = r_start;
  assign msg_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Desc   : Directed bench for uart_tx_arbiter with FIFO and UART models.
// Rev    : 1.0  initial release
// ============================================================================

module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_empty;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_rden;
  logic [W-1:0]      uart_data;
  logic              uart_start;
  logic              uart_busy = 1'b0;
  logic [NREQ-1:0]   grant;
  logic              msg_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_empty  (req_empty),
    .req_data   (req_data),
    .req_rden   (req_rden),
    .uart_data  (uart_data),
    .uart_start (uart_start),
    .uart_busy  (uart_busy),
    .grant      (grant),
    .msg_done   (msg_done)
  );

  // Source FIFOs with one-cycle read latency.
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  logic [5:0] wp0 = '0, wp1 = '0, rp0 = '0, rp1 = '0;
  logic [7:0] q0 = '0, q1 = '0;

  assign req_empty = {wp1 == rp1, wp0 == rp0};
  assign req_data  = {q1, q0};

  always @(posedge clk) begin
    if (req_rden[0]) begin
      q0  <= mem0[rp0];
      rp0 <= rp0 + 6'd1;
    end
    if (req_rden[1]) begin
      q1  <= mem1[rp1];
      rp1 <= rp1 + 6'd1;
    end
  end

  // UART: accepts start after start_delay cycles, then busy for busy_len cycles.
  int         start_delay = 0;
  int         busy_len    = 10;
  int         dly         = 0;
  int         bcnt        = 0;
  logic [7:0] tx_log [$];

  always @(posedge clk) begin
    if (uart_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) uart_busy <= 1'b0;
    end else if (uart_start) begin
      if (dly == start_delay) begin
        uart_busy <= 1'b1;
        bcnt      <= busy_len;
        dly       <= 0;
        tx_log.push_back(uart_data);
      end else begin
        dly <= dly + 1;
      end
    end else begin
      dly <= 0;
    end
  end

  int         rden_cnt0  = 0;
  int         rden_cnt1  = 0;
  int         start_rise = 0;
  int         done_cnt   = 0;
  logic       prev_start = 1'b0;
  logic [1:0] prev_grant = '0;
  logic [1:0] ghist [$];

  always @(negedge clk) begin
    rden_cnt0 <= rden_cnt0 + int'(req_rden[0]);
    rden_cnt1 <= rden_cnt1 + int'(req_rden[1]);
    if (uart_start && !prev_start) start_rise <= start_rise + 1;
    if (msg_done) done_cnt <= done_cnt + 1;
    if (grant != prev_grant) ghist.push_back(grant);
    prev_start <= uart_start;
    prev_grant <= grant;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int src, input logic [7:0] b);
    if (src == 0) begin
      mem0[wp0] = b;
      wp0 = wp0 + 6'd1;
    end else begin
      mem1[wp1] = b;
      wp1 = wp1 + 6'd1;
    end
  endtask

  task automatic push(input int src, input string s, input bit term);
    for (int i = 0; i < s.len(); i++) put(src, s[i]);
    if (term) put(src, 8'h00);
  endtask

  task automatic wait_done(input string tag, input int max);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (i < max && msg_done !== 1'b1);
    chk(tag, {31'd0, msg_done}, 32'd1);
  endtask

  task automatic wait_start(input string tag, input int max);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (i < max && uart_start !== 1'b1);
    chk(tag, {31'd0, uart_start}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, gb, r0, r1, sr, dc;

    // Reset values, with source 0 already holding "AB\0".
    reset = 1'b1;
    repeat (3) @(negedge clk);
    push(0, "AB", 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_rden", req_rden, 0);
    chk("rst_start", uart_start, 0);
    chk("rst_done", msg_done, 0);
    chk("rst_data", uart_data, 0);

    // Single message "AB": cycle-exact start of the sequence.
    lb = tx_log.size(); r0 = rden_cnt0; sr = start_rise;
    reset = 1'b0;
    @(negedge clk);
    chk("ab_grant", grant, 2'b01);
    chk("ab_rden", req_rden, 2'b01);
    @(negedge clk);
    chk("ab_latch_rden", req_rden, 0);
    chk("ab_latch_start", uart_start, 0);
    @(negedge clk);
    chk("ab_start", uart_start, 1);
    chk("ab_data", uart_data, 8'h41);
    wait_done("ab_done", 300);
    chk("ab_done_grant", grant, 0);
    @(negedge clk);
    chk("ab_done_pulse", msg_done, 0);
    repeat (2) @(negedge clk);
    chk("ab_nbytes", tx_log.size() - lb, 2);
    chk("ab_byte0", tx_log[lb], 8'h41);
    chk("ab_byte1", tx_log[lb+1], 8'h42);
    chk("ab_starts", start_rise - sr, 2);
    chk("ab_rden0", rden_cnt0 - r0, 3);

    // Both sources pending at reset release: pointer restarts at 0.
    reset = 1'b1;
    push(0, "X", 1'b1);
    push(1, "Y", 1'b1);
    repeat (2) @(negedge clk);
    lb = tx_log.size(); gb = ghist.size();
    reset = 1'b0;
    wait_done("xy_done1", 300);
    wait_done("xy_done2", 300);
    repeat (2) @(negedge clk);
    chk("xy_byte0", tx_log[lb], "X");
    chk("xy_byte1", tx_log[lb+1], "Y");
    chk("xy_ghist_n", ghist.size() - gb, 4);
    chk("xy_ghist0", ghist[gb], 2'b01);
    chk("xy_ghist1", ghist[gb+1], 2'b00);
    chk("xy_ghist2", ghist[gb+2], 2'b10);
    chk("xy_ghist3", ghist[gb+3], 2'b00);

    // Source 0 with two messages and source 1 with one.
    lb = tx_log.size();
    push(0, "a", 1'b1);
    push(0, "c", 1'b1);
    push(1, "d", 1'b1);
    wait_done("rr_done1", 300);
    wait_done("rr_done2", 300);
    wait_done("rr_done3", 300);
    repeat (2) @(negedge clk);
    chk("rr_byte0", tx_log[lb], "a");
`ifdef ARB_FIXED_PRIO_EN
    chk("rr_byte1", tx_log[lb+1], "c");
    chk("rr_byte2", tx_log[lb+2], "d");
`else
    chk("rr_byte1", tx_log[lb+1], "d");
    chk("rr_byte2", tx_log[lb+2], "c");
`endif

    // Source 1 stalls mid-message; source 0 must wait.
    lb = tx_log.size();
    push(1, "H", 1'b0);
    repeat (30) @(negedge clk);
    chk("hold_grant_a", grant, 2'b10);
    chk("hold_byte_h", tx_log[lb], "H");
    push(0, "Z", 1'b1);
    r0 = rden_cnt0; r1 = rden_cnt1; dc = done_cnt;
    repeat (50) @(negedge clk);
    chk("hold_grant_b", grant, 2'b10);
    chk("hold_rden0", rden_cnt0 - r0, 0);
    chk("hold_rden1", rden_cnt1 - r1, 0);
    chk("hold_done", done_cnt - dc, 0);
    push(1, "I", 1'b1);
    wait_done("hold_done_i", 300);
    chk("hold_grant_end", grant, 0);
    wait_done("hold_done_z", 300);
    repeat (2) @(negedge clk);
    chk("hold_nbytes", tx_log.size() - lb, 3);
    chk("hold_byte_i", tx_log[lb+1], "I");
    chk("hold_byte_z", tx_log[lb+2], "Z");

    // Reset pulse while waiting in START.
    start_delay = 5;
    lb = tx_log.size();
    push(0, "R", 1'b1);
    wait_start("rs_start", 50);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_start_clr", uart_start, 0);
    chk("rs_grant_clr", grant, 0);
    chk("rs_rden_clr", req_rden, 0);
    chk("rs_data_clr", uart_data, 0);
    chk("rs_done_clr", msg_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_regrant", grant, 2'b01);
    chk("rs_reread", req_rden, 2'b01);
    wait_done("rs_done", 300);
    repeat (2) @(negedge clk);
    chk("rs_nbytes", tx_log.size() - lb, 0);

    // Busy rises three cycles after start.
    start_delay = 2;
    push(1, "K", 1'b1);
    wait_start("bd_start", 50);
    chk("bd_s0_busy", uart_busy, 0);
    chk("bd_data", uart_data, "K");
    @(negedge clk);
    chk("bd_s1_start", uart_start, 1);
    chk("bd_s1_busy", uart_busy, 0);
    @(negedge clk);
    chk("bd_s2_start", uart_start, 1);
    chk("bd_s2_busy", uart_busy, 0);
    @(negedge clk);
    chk("bd_s3_start", uart_start, 1);
    chk("bd_s3_busy", uart_busy, 1);
    @(negedge clk);
    chk("bd_s4_start", uart_start, 0);
    wait_done("bd_done", 300);
    chk("bd_data_hold", uart_data, "K");
    chk("bd_grant_end", grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
